// File: rtl/risk_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: FSM states and hazard classes.
package risk_unit_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } hazard_t;

endpackage

// File: rtl/risk_detect.sv
// Combinational hazard classifier: compares ID source registers against EX/MEM destinations.
module risk_detect
  import risk_unit_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] i_id_rs,
  input  logic [REG_BITS-1:0] i_id_rt,
  input  logic                i_id_uses_rt,
  input  logic                i_id_branch,
  input  logic                i_ex_mem_read,
  input  logic                i_ex_reg_write,
  input  logic [REG_BITS-1:0] i_ex_dst,
  input  logic                i_mem_mem_read,
  input  logic [REG_BITS-1:0] i_mem_dst,
  output hazard_t             o_hazard
);

  logic w_ex_match;
  logic w_mem_match;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  assign w_ex_match  = (i_ex_dst != '0) &&
                       ((i_ex_dst == i_id_rs) || (i_id_uses_rt && (i_ex_dst == i_id_rt)));
  assign w_mem_match = (i_mem_dst != '0) &&
                       ((i_mem_dst == i_id_rs) || (i_id_uses_rt && (i_mem_dst == i_id_rt)));

  always_comb begin
    o_hazard = NONE;
    if (i_id_branch && i_ex_mem_read && w_ex_match) begin
      o_hazard = TWO;
    end else if (i_ex_mem_read && w_ex_match) begin
      o_hazard = ONE;
    end else if (i_id_branch && i_ex_reg_write && w_ex_match) begin
      o_hazard = ONE;
    end else if (i_id_branch && i_mem_mem_read && w_mem_match) begin
      o_hazard = ONE;
    end
  end

endmodule

// File: rtl/risk_unit.sv
// Pipeline hazard unit: bubble insertion, redirect flush, halt drain and bubble statistics.
module risk_unit
  import risk_unit_pkg::*;
#(
  parameter int REG_BITS     = 5,
  parameter int CNT_BITS     = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [REG_BITS-1:0] i_id_rs,
  input  logic [REG_BITS-1:0] i_id_rt,
  input  logic                i_id_uses_rt,
  input  logic                i_id_branch,
  input  logic                i_id_halt,
  input  logic                i_branch_taken,
  input  logic                i_ex_mem_read,
  input  logic                i_ex_reg_write,
  input  logic [REG_BITS-1:0] i_ex_dst,
  input  logic                i_mem_mem_read,
  input  logic [REG_BITS-1:0] i_mem_dst,
  output logic                o_risk,
  output logic                o_pc_write,
  output logic                o_if_id_write,
  output logic                o_if_id_flush,
  output logic                o_halted,
  output logic [CNT_BITS-1:0] o_bubbles
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW-1:0]         r_drain_cnt;
  logic [DW-1:0]         w_drain_nxt;
  logic [CNT_BITS-1:0]   r_bubbles;
  hazard_t               w_hazard;
  logic                  w_active;

  risk_detect #(
    .REG_BITS(REG_BITS)
  ) u_risk_detect (
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_uses_rt  (i_id_uses_rt),
    .i_id_branch   (i_id_branch),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_reg_write(i_ex_reg_write),
    .i_ex_dst      (i_ex_dst),
    .i_mem_mem_read(i_mem_mem_read),
    .i_mem_dst     (i_mem_dst),
    .o_hazard      (w_hazard)
  );

  // Outputs are quiet both while frozen and while reset is held low.
  assign w_active = i_enable && i_reset;

  always_comb begin
    w_state_nxt   = r_state;
    w_drain_nxt   = r_drain_cnt;
    o_risk        = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    if (w_active) begin
      case (r_state)
        RUN: begin
          if (w_hazard != NONE) begin
            o_risk = 1'b1;
            if (w_hazard == TWO) begin
              w_state_nxt = STALL;
            end
          end else if (i_id_halt) begin
            w_state_nxt = DRAIN;
            w_drain_nxt = DW'(DRAIN_CYCLES - 1);
          end else begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
            o_if_id_flush = i_branch_taken;
          end
        end
        STALL: begin
          o_risk      = 1'b1;
          w_state_nxt = RUN;
        end
        DRAIN: begin
          if (r_drain_cnt == '0) begin
            w_state_nxt = HALTED;
          end else begin
            w_drain_nxt = r_drain_cnt - DW'(1);
          end
        end
        HALTED: begin
          w_state_nxt = HALTED;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  assign o_halted  = i_reset && (r_state == HALTED);
  assign o_bubbles = r_bubbles;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_bubbles   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (o_risk && (r_bubbles != '1)) begin
        r_bubbles <= r_bubbles + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_risk_unit.sv
// Directed bench for risk_unit: single-cycle vector table plus hand-written multi-cycle sequences.
module tb_risk_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic        id_uses_rt, id_branch, id_halt, br_taken;
  logic        ex_mr, ex_rw, mem_mr;
  logic        o_risk, o_pc_write, o_if_id_write, o_if_id_flush, o_halted;
  logic [15:0] o_bubbles;

  int total = 0;
  int bad = 0;
  int exp_bub = 0;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, branch, taken, exmr, exrw;
    logic [4:0] exdst;
    logic       memmr;
    logic [4:0] memdst;
    logic       e_risk, e_flush, e_stall;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  risk_unit #(
    .REG_BITS    (5),
    .CNT_BITS    (16),
    .DRAIN_CYCLES(3)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (id_uses_rt),
    .i_id_branch   (id_branch),
    .i_id_halt     (id_halt),
    .i_branch_taken(br_taken),
    .i_ex_mem_read (ex_mr),
    .i_ex_reg_write(ex_rw),
    .i_ex_dst      (ex_dst),
    .i_mem_mem_read(mem_mr),
    .i_mem_dst     (mem_dst),
    .o_risk        (o_risk),
    .o_pc_write    (o_pc_write),
    .o_if_id_write (o_if_id_write),
    .o_if_id_flush (o_if_id_flush),
    .o_halted      (o_halted),
    .o_bubbles     (o_bubbles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic risk, input logic pc, input logic ifid,
                         input logic flush, input logic halted);
    chk({name, ".risk"}, 32'(o_risk), 32'(risk));
    chk({name, ".pc_write"}, 32'(o_pc_write), 32'(pc));
    chk({name, ".if_id_write"}, 32'(o_if_id_write), 32'(ifid));
    chk({name, ".flush"}, 32'(o_if_id_flush), 32'(flush));
    chk({name, ".halted"}, 32'(o_halted), 32'(halted));
  endtask

  task automatic idle_in();
    id_rs = '0; id_rt = '0; id_uses_rt = 0; id_branch = 0; id_halt = 0; br_taken = 0;
    ex_mr = 0; ex_rw = 0; ex_dst = '0; mem_mr = 0; mem_dst = '0;
  endtask

  task automatic addv(input logic [4:0] rs, input logic [4:0] rt, input logic uses, input logic br,
                      input logic tk, input logic exmr, input logic exrw, input logic [4:0] exdst,
                      input logic memmr, input logic [4:0] memdst,
                      input logic er, input logic ef, input logic es);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses; v.branch = br; v.taken = tk;
    v.exmr = exmr; v.exrw = exrw; v.exdst = exdst; v.memmr = memmr; v.memdst = memdst;
    v.e_risk = er; v.e_flush = ef; v.e_stall = es;
    vq.push_back(v);
  endtask

  task automatic load_use5();
    idle_in(); id_rs = 5'd5; ex_mr = 1; ex_rw = 1; ex_dst = 5'd5;
  endtask

  task automatic branch_after_load3();
    idle_in(); id_rs = 5'd3; id_branch = 1; ex_mr = 1; ex_rw = 1; ex_dst = 5'd3;
  endtask

  initial begin
    //    rs  rt  use br tk exmr exrw exdst memmr memdst  risk flush stall
    addv(0,  0,  0,  0, 0, 0,   0,   0,    0,    0,      0,   0,    0);
    addv(5,  0,  0,  0, 0, 1,   1,   5,    0,    0,      1,   0,    0);
    addv(0,  0,  0,  0, 0, 1,   1,   0,    0,    0,      0,   0,    0);
    addv(1,  9,  1,  0, 0, 1,   1,   9,    0,    0,      1,   0,    0);
    addv(1,  9,  0,  0, 0, 1,   1,   9,    0,    0,      0,   0,    0);
    addv(7,  0,  0,  1, 1, 0,   1,   7,    0,    0,      1,   0,    0);
    addv(7,  0,  0,  0, 0, 0,   1,   7,    0,    0,      0,   0,    0);
    addv(2,  4,  1,  1, 0, 0,   0,   0,    1,    4,      1,   0,    0);
    addv(4,  0,  0,  0, 0, 0,   0,   0,    1,    4,      0,   0,    0);
    addv(1,  0,  0,  1, 1, 0,   1,   2,    0,    0,      0,   1,    0);
    addv(3,  0,  0,  1, 0, 1,   1,   3,    0,    0,      1,   0,    1);
    addv(0,  0,  0,  1, 0, 0,   0,   0,    1,    0,      0,   0,    0);
    addv(6,  0,  0,  1, 0, 0,   0,   0,    0,    6,      0,   0,    0);
    addv(1,  8,  0,  1, 0, 0,   1,   8,    0,    0,      0,   0,    0);

    idle_in();
    rst_n = 0;
    #2;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.bubbles", 32'(o_bubbles), 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vq[i]) begin
      @(negedge clk);
      id_rs = vq[i].rs; id_rt = vq[i].rt; id_uses_rt = vq[i].uses_rt;
      id_branch = vq[i].branch; br_taken = vq[i].taken; id_halt = 0;
      ex_mr = vq[i].exmr; ex_rw = vq[i].exrw; ex_dst = vq[i].exdst;
      mem_mr = vq[i].memmr; mem_dst = vq[i].memdst;
      #2;
      chk_out($sformatf("vec%0d", i), vq[i].e_risk, !vq[i].e_risk, !vq[i].e_risk,
              vq[i].e_flush, 0);
      @(negedge clk);
      idle_in();
      #2;
      chk_out($sformatf("vec%0d.next", i), vq[i].e_stall, !vq[i].e_stall, !vq[i].e_stall, 0, 0);
      exp_bub += int'(vq[i].e_risk) + int'(vq[i].e_stall);
      @(negedge clk);
      #2;
      chk_out($sformatf("vec%0d.run", i), 0, 1, 1, 0, 0);
      chk($sformatf("vec%0d.bubbles", i), 32'(o_bubbles), 32'(exp_bub));
    end

    // Taken branch blocked by an ALU hazard, then flushed once the hazard clears.
    @(negedge clk);
    idle_in(); id_rs = 5'd7; id_branch = 1; br_taken = 1; ex_rw = 1; ex_dst = 5'd7;
    #2;
    chk_out("flushprio.stall", 1, 0, 0, 0, 0);
    @(negedge clk);
    ex_rw = 0; ex_dst = '0;
    #2;
    chk_out("flushprio.after", 0, 1, 1, 1, 0);
    exp_bub += 1;

    // Freeze while in STALL: outputs drop, state and count hold.
    @(negedge clk);
    branch_after_load3();
    #2;
    chk_out("frz.hazard", 1, 0, 0, 0, 0);
    @(negedge clk);
    idle_in(); en = 0;
    #2;
    chk_out("frz.off1", 0, 0, 0, 0, 0);
    @(negedge clk);
    load_use5();
    #2;
    chk_out("frz.off2", 0, 0, 0, 0, 0);
    chk("frz.bubbles", 32'(o_bubbles), 32'(exp_bub + 1));
    @(negedge clk);
    idle_in(); en = 1;
    #2;
    chk_out("frz.stall_resumed", 1, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk_out("frz.run", 0, 1, 1, 0, 0);
    exp_bub += 2;
    chk("frz.bubbles2", 32'(o_bubbles), 32'(exp_bub));

    // Asynchronous reset in the middle of a STALL cycle.
    @(negedge clk);
    branch_after_load3();
    @(negedge clk);
    idle_in();
    #2;
    chk_out("rststall.stall", 1, 0, 0, 0, 0);
    #1;
    rst_n = 0;
    #1;
    chk_out("rststall.inreset", 0, 0, 0, 0, 0);
    chk("rststall.bubbles", 32'(o_bubbles), 0);
    @(negedge clk);
    rst_n = 1;
    #2;
    chk_out("rststall.run", 0, 1, 1, 0, 0);

    // Halt with a freeze inside DRAIN, then terminal HALTED.
    @(negedge clk);
    idle_in(); id_halt = 1;
    #2;
    chk_out("halt.take", 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_in();
    #2;
    chk_out("halt.drain1", 0, 0, 0, 0, 0);
    en = 0;
    repeat (3) @(negedge clk);
    #2;
    chk_out("halt.frozen", 0, 0, 0, 0, 0);
    en = 1;
    @(negedge clk);
    #2;
    chk_out("halt.drain2", 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk_out("halt.drain3", 0, 0, 0, 0, 0);
    @(negedge clk);
    load_use5(); br_taken = 1;
    #2;
    chk_out("halt.halted", 0, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    chk_out("halt.terminal", 0, 0, 0, 0, 1);
    chk("halt.bubbles", 32'(o_bubbles), 0);

    // Halt coinciding with a hazard, then reset in the middle of DRAIN.
    @(negedge clk);
    rst_n = 0;
    idle_in();
    #2;
    chk_out("rst2.inreset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    load_use5(); id_halt = 1;
    #2;
    chk_out("halthz.hazard", 1, 0, 0, 0, 0);
    @(negedge clk);
    idle_in(); id_halt = 1;
    #2;
    chk_out("halthz.take", 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_in();
    #2;
    chk_out("halthz.drain1", 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk_out("halthz.drain2", 0, 0, 0, 0, 0);
    #1;
    rst_n = 0;
    #1;
    chk_out("rstdrain.inreset", 0, 0, 0, 0, 0);
    chk("rstdrain.bubbles", 32'(o_bubbles), 0);
    @(negedge clk);
    rst_n = 1;
    #2;
    chk_out("rstdrain.run", 0, 1, 1, 0, 0);
    repeat (4) @(negedge clk);
    #2;
    chk_out("rstdrain.still_run", 0, 1, 1, 0, 0);

    // Saturation of the bubble counter, then freeze at saturation.
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    load_use5();
    repeat (65534) @(negedge clk);
    #2;
    chk("sat.fffe", 32'(o_bubbles), 32'h0000_FFFE);
    repeat (3) @(negedge clk);
    #2;
    chk("sat.ffff", 32'(o_bubbles), 32'h0000_FFFF);
    chk_out("sat.risk", 1, 0, 0, 0, 0);
    @(negedge clk);
    en = 0;
    #2;
    chk_out("sat.frozen", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    chk("sat.frozen_cnt", 32'(o_bubbles), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
